// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM operand skewer.
//   - DEFAULT_DIM / DEFAULT_DATA_W : default array edge length and element width
//   - skew_state_e                 : LOAD / STREAM / DONE state encoding
//   - LANE_SKEW, lane_hit()        : wavefront lane-select helpers
package gemm_pkg;

  localparam int DEFAULT_DIM    = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } skew_state_e;

  // Each lane lags its neighbour by one beat, forming the diagonal wavefront.
  localparam int LANE_SKEW = 1;

  // True when element k of lane `lane` sits on the wavefront at beat t.
  function automatic logic lane_hit(input int t, input int lane, input int k);
    return t == lane * LANE_SKEW + k;
  endfunction

endpackage

// File: rtl/gemm_operand_skewer_if.sv
// Bus bundle for gemm_operand_skewer.
//   Load side  : a_valid/a_word (A rows), b_valid/b_word (B columns), start
//   Array side : sa_a (west edge), sa_b (north edge), sa_valid
//   Status     : ready, done, err
// master = controller/testbench, slave = skewer.
interface gemm_operand_skewer_if #(
  parameter int DIM    = gemm_pkg::DEFAULT_DIM,
  parameter int DATA_W = gemm_pkg::DEFAULT_DATA_W
);

  localparam int WORD_W = DIM * DATA_W;

  logic              a_valid;
  logic [WORD_W-1:0] a_word;
  logic              b_valid;
  logic [WORD_W-1:0] b_word;
  logic              start;
  logic [WORD_W-1:0] sa_a;
  logic [WORD_W-1:0] sa_b;
  logic              sa_valid;
  logic              ready;
  logic              done;
  logic              err;

  modport master (
    output a_valid, a_word, b_valid, b_word, start,
    input  sa_a, sa_b, sa_valid, ready, done, err
  );

  modport slave (
    input  a_valid, a_word, b_valid, b_word, start,
    output sa_a, sa_b, sa_valid, ready, done, err
  );

endinterface

// File: rtl/gemm_tile_buffer.sv
// DIM x DIM tile register file with a single row write port.
//   clk, reset_n : clock, async active-low reset (pointer only)
//   wr_en        : write request; accepted only while not full
//   wr_data      : row to store at the current write pointer
//   clear        : rewind the write pointer to row 0
//   rows         : all stored rows, row r at rows[r]
//   full         : DIM rows have been written since the last clear
module gemm_tile_buffer #(
  parameter int DIM    = 4,
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [DIM*DATA_W-1:0]            wr_data,
  input  logic                             clear,
  output logic [DIM-1:0][DIM*DATA_W-1:0]   rows,
  output logic                             full
);

  localparam int PTR_W = $clog2(DIM + 1);

  logic [PTR_W-1:0] ptr_q;

  // Pointer saturates at DIM; a write at DIM is simply not accepted.
  assign full = (ptr_q == PTR_W'(DIM));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
    end else if (wr_en && !full) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  // NOTE: the row storage has no reset; ptr_q alone decides which rows are
  // valid, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int r = 0; r < DIM; r++) begin
      if (wr_en && !full && ptr_q == PTR_W'(r)) begin
        rows[r] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/gemm_operand_skewer.sv
// Operand skewer in front of a DIM x DIM systolic array.
// Buffers DIM A rows and DIM B columns, then on start streams them as a
// diagonal wavefront (lane i delayed by i beats) for 2*DIM-1 beats,
// followed by a one-cycle done pulse.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : a_valid/a_word, b_valid/b_word, start in;
//                  sa_a, sa_b, sa_valid, ready, done, err out
// Optional: define GEMM_SKEW_ERR_EN to build a sticky err flag that is set
// by any dropped load word; otherwise err is tied low.
module gemm_operand_skewer
  import gemm_pkg::*;
#(
  parameter int DIM    = DEFAULT_DIM,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gemm_operand_skewer_if.slave  bus
);

  localparam int WORD_W = DIM * DATA_W;
  localparam int T_W    = $clog2(2 * DIM);
  localparam logic [T_W-1:0] LAST_T = T_W'(2 * DIM - 2);

  skew_state_e state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic           clear_ptrs;
  logic           in_load;
  logic           a_full, b_full;
  logic           ready;

  logic [DIM-1:0][WORD_W-1:0] a_rows, b_rows;
  logic [WORD_W-1:0]          beat_a, beat_b;

  logic [WORD_W-1:0] sa_a_q, sa_b_q;
  logic              sa_valid_q, done_q;

  assign in_load = (state_q == ST_LOAD);
  assign ready   = in_load && a_full && b_full;

  gemm_tile_buffer #(.DIM(DIM), .DATA_W(DATA_W)) u_a_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.a_valid && in_load),
    .wr_data (bus.a_word),
    .clear   (clear_ptrs),
    .rows    (a_rows),
    .full    (a_full)
  );

  // B columns are stored as rows, so both buffers share one skew rule.
  gemm_tile_buffer #(.DIM(DIM), .DATA_W(DATA_W)) u_b_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.b_valid && in_load),
    .wr_data (bus.b_word),
    .clear   (clear_ptrs),
    .rows    (b_rows),
    .full    (b_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    clear_ptrs = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        t_d = '0;
        if (bus.start && ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (t_q == LAST_T) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = ST_LOAD;
        clear_ptrs = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Lane i at beat t carries element t-i of stored row i; off-diagonal lanes are zero.
  always_comb begin
    beat_a = '0;
    beat_b = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (lane_hit(int'(t_q), i, k)) begin
          beat_a[i*DATA_W +: DATA_W] = a_rows[i][k*DATA_W +: DATA_W];
          beat_b[i*DATA_W +: DATA_W] = b_rows[i][k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered outputs: the beat computed during STREAM cycle t appears one
  // cycle later, and done follows the DONE state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_a_q     <= '0;
      sa_b_q     <= '0;
      sa_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sa_valid_q <= (state_q == ST_STREAM);
      sa_a_q     <= (state_q == ST_STREAM) ? beat_a : '0;
      sa_b_q     <= (state_q == ST_STREAM) ? beat_b : '0;
      done_q     <= (state_q == ST_DONE);
    end
  end

  assign bus.sa_a     = sa_a_q;
  assign bus.sa_b     = sa_b_q;
  assign bus.sa_valid = sa_valid_q;
  assign bus.ready    = ready;
  assign bus.done     = done_q;

`ifdef GEMM_SKEW_ERR_EN
  logic a_drop, b_drop, err_q;

  // A word is dropped when it arrives outside LOAD or onto a full buffer.
  assign a_drop = bus.a_valid && !(in_load && !a_full);
  assign b_drop = bus.b_valid && !(in_load && !b_full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_q | a_drop | b_drop;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/gemm_operand_skewer.md
GEMM_OPERAND_SKEWER -- requirements
Module: gemm_operand_skewer

Interface
REQ-001 SHALL have parameter DIM, default 4, meaning systolic array edge length (rows of A tile, columns of B tile).
REQ-002 SHALL have parameter DATA_W, default 8, meaning signed element width; word width is DIM*DATA_W (32 at defaults).
REQ-003 SHALL have port clk, input, 1, clock; all state rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a_valid, input, 1, a_word carries one A row this cycle.
REQ-006 SHALL have port a_word, input, DIM*DATA_W, A row r, element k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port b_valid, input, 1, b_word carries one B column this cycle.
REQ-008 SHALL have port b_word, input, DIM*DATA_W, B column c, element k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port start, input, 1, request to stream the loaded tile (driven by the controller's start_compute).
REQ-010 SHALL have port sa_a, output, DIM*DATA_W, skewed west-edge feed, lane i drives array row i.
REQ-011 SHALL have port sa_b, output, DIM*DATA_W, skewed north-edge feed, lane j drives array column j.
REQ-012 SHALL have port sa_valid, output, 1, sa_a/sa_b are meaningful this cycle.
REQ-013 SHALL have port ready, output, 1, both buffers full and block in LOAD.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the last skewed beat.
REQ-015 SHALL have port err, output, 1, sticky overrun flag (see Configuration).

Function
REQ-016 SHALL implement states LOAD, STREAM, DONE; encoding in shared package.
REQ-017 In LOAD, each a_valid SHALL write a_word to A buffer row a_ptr and increment a_ptr; b_valid likewise with b_ptr; both accepted in the same cycle.
REQ-018 a_ptr/b_ptr SHALL saturate at DIM; a word arriving with its pointer at DIM, or outside LOAD, SHALL be dropped and buffers unchanged.
REQ-019 ready SHALL be 1 iff state==LOAD and a_ptr==DIM and b_ptr==DIM.
REQ-020 start while ready==0 SHALL be ignored; start while ready==1 SHALL move to STREAM next cycle with beat counter t=0.
REQ-021 STREAM SHALL last exactly 2*DIM-1 cycles (t=0..2*DIM-2), sa_valid=1 throughout.
REQ-022 At beat t, sa_a lane i SHALL equal A[i][t-i] and sa_b lane j SHALL equal B[t-j][j] when 0<=t-i<DIM (resp. t-j), else zero.
REQ-023 Outputs SHALL be registered: first beat appears the cycle after STREAM entry; start-to-first-beat latency 2 cycles.
REQ-024 After t=2*DIM-2 state SHALL go to DONE for one cycle with done=1, sa_valid=0, sa_a=sa_b=0, pointers cleared, then LOAD.
REQ-025 start asserted during STREAM or DONE SHALL be ignored.

Reset
REQ-026 reset_n low SHALL immediately force state=LOAD, a_ptr=b_ptr=0, t=0, sa_a=sa_b=0, sa_valid=0, done=0, ready=0, err=0; buffer contents need not reset.
REQ-027 Reset asserted mid-STREAM SHALL abort the stream with no done pulse; after release the block requires a full reload.

Configuration
REQ-028 Macro GEMM_SKEW_ERR_EN SHALL, when defined, set err on any dropped word (REQ-018), held until reset.
REQ-029 Without GEMM_SKEW_ERR_EN, err SHALL be constant 0 and no error logic SHALL be synthesized; all other behaviour identical.

Structure
REQ-030 Shared package gemm_pkg SHALL hold state enum, DIM/DATA_W defaults, and lane-select helper constants.
REQ-031 One sub-module gemm_tile_buffer (DIM x DIM register file, row write port, pointer, full flag) SHALL be instantiated twice, for A and B.

Verification
REQ-032 Load A rows 0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D, B identically, start -> 7 beats; beat0 sa_a=0x00000001, beat3 sa_a=0x0D0A0704, beat6 sa_a=0x10000000; done pulses 1 cycle after beat6.
REQ-033 Assert start after 3 A rows and 4 B rows -> no sa_valid, ready=0; 4th A row then start -> stream begins 2 cycles later.
REQ-034 Send 5 A rows with GEMM_SKEW_ERR_EN -> 5th dropped, err=1 until reset, stream uses first 4 rows; without macro err stays 0.
REQ-035 Same-cycle a_valid and b_valid for 4 cycles -> ready=1 on cycle 5.
REQ-036 Deassert reset_n at beat 3 -> outputs zero immediately, no done; after release ready=0 until 4+4 words reloaded.
REQ-037 Back-to-back tiles: reload during LOAD right after done, start -> second stream correct, no residue from first tile.
